// File: rtl/div_demux_if.sv
// Handshake and data bundle for the divide-and-steer block.
interface div_demux_if;
  localparam int unsigned DVD_W = 16;
  localparam int unsigned DVS_W = 8;
  localparam int unsigned SEL_W = 2;

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [DVD_W-1:0] out0;
  logic [DVD_W-1:0] out1;
  logic [DVD_W-1:0] out2;
  logic [DVD_W-1:0] out3;
  logic [DVS_W-1:0] rem;

  // Requester side: issues operands, observes results.
  modport master (
    output start, dividend, divisor, sel,
    input  busy, done, div_by_zero, out0, out1, out2, out3, rem
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor, sel,
    output busy, done, div_by_zero, out0, out1, out2, out3, rem
  );
endinterface

// File: rtl/div_demux.sv
// Sequential 16/8 unsigned restoring divider; quotient steered to one of four
// destination registers chosen by the select latched at start.
module div_demux (
  input  logic       clk,
  input  logic       rst_n,
  div_demux_if.slave bus
);
  localparam int unsigned DVD_W = 16;
  localparam int unsigned DVS_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned N_OUT = 4;

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t state, state_nxt;

  logic accept;
  logic accept_zero;
  logic iterate;
  logic finish;

  logic [DVD_W-1:0] dvd_sh;
  logic [DVS_W-1:0] dvs;
  logic [1:0]       sel_q;
  logic [DVD_W-1:0] quo;
  logic [DVS_W-1:0] prem;
  logic [CNT_W-1:0] cnt;

  logic [DVS_W:0]   p_shift;
  logic             p_ge;
  logic [DVS_W-1:0] p_sub;

  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [DVD_W-1:0] outs [N_OUT];
  logic [DVS_W-1:0] rem_q;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    accept_zero = 1'b0;
    iterate     = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            accept    = 1'b1;
            state_nxt = DIV;
          end else begin
            accept_zero = 1'b1;
            state_nxt   = FIN;
          end
        end
      end
      DIV: begin
        iterate = 1'b1;
        if (cnt == '0) state_nxt = FIN;
      end
      FIN: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // The partial remainder is kept 9 bits wide only for the compare; after a
  // step it is always below the divisor, so 8 bits are stored.
  always_comb begin
    p_shift = {prem, dvd_sh[DVD_W-1]};
    p_ge    = p_shift >= {1'b0, dvs};
    p_sub   = DVS_W'(p_shift - {1'b0, dvs});
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh <= '0;
      dvs    <= '0;
      sel_q  <= '0;
      quo    <= '0;
      prem   <= '0;
      cnt    <= '0;
    end else if (accept) begin
      dvd_sh <= bus.dividend;
      dvs    <= bus.divisor;
      sel_q  <= bus.sel;
      quo    <= '0;
      prem   <= '0;
      cnt    <= CNT_W'(15);
    end else if (accept_zero) begin
      sel_q  <= bus.sel;
      quo    <= '1;
      prem   <= bus.dividend[DVS_W-1:0];
    end else if (iterate) begin
      dvd_sh <= {dvd_sh[DVD_W-2:0], 1'b0};
      prem   <= p_ge ? p_sub : p_shift[DVS_W-1:0];
      quo    <= {quo[DVD_W-2:0], p_ge};
      cnt    <= cnt - CNT_W'(1);
    end
  end

  // Registered status and destination outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      rem_q  <= '0;
      for (int i = 0; i < N_OUT; i++) outs[i] <= '0;
    end else begin
      done_q <= finish;
      if (accept || accept_zero) begin
        busy_q <= 1'b1;
        dz_q   <= accept_zero;
      end else if (finish) begin
        busy_q      <= 1'b0;
        outs[sel_q] <= quo;
        rem_q       <= prem;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.out0        = outs[0];
  assign bus.out1        = outs[1];
  assign bus.out2        = outs[2];
  assign bus.out3        = outs[3];
  assign bus.rem         = rem_q;
endmodule

// File: tb/tb_div_demux.sv
// Self-checking bench for div_demux: vector table plus hand-built corner sequences.
module tb_div_demux;
  logic clk;
  logic rst_n;

  div_demux_if bus ();

  div_demux dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [1:0]  sel;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } exp_t;

  int vectors     = 0;
  int miscompares = 0;

  vec_t        vecs [$];
  exp_t        sb   [$];
  logic [15:0] shadow [4];
  logic [7:0]  shadow_rem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] out_of(input int i);
    case (i)
      0:       return bus.out0;
      1:       return bus.out1;
      2:       return bus.out2;
      default: return bus.out3;
    endcase
  endfunction

  // Compare all four destinations and rem against the bench's shadow copy.
  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_out%0d", tag, i), 32'(out_of(i)), 32'(shadow[i]));
    chk($sformatf("%s_rem", tag), 32'(bus.rem), 32'(shadow_rem));
  endtask

  function automatic vec_t mk(input logic [15:0] dvd, input logic [7:0] dvs, input logic [1:0] sel,
                              input logic [15:0] q, input logic [7:0] r, input logic dz);
    vec_t v;
    v.dvd = dvd; v.dvs = dvs; v.sel = sel; v.q = q; v.r = r; v.dz = dz;
    return v;
  endfunction

  // Issue one operation starting now (caller sits just after a rising edge),
  // scramble the operands after acceptance, then wait for done and check.
  task automatic do_op(input vec_t v);
    exp_t e;
    int   lat;
    int   lat_exp;
    lat_exp      = v.dz ? 1 : 17;
    bus.dividend = v.dvd;
    bus.divisor  = v.dvs;
    bus.sel      = v.sel;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    bus.sel      = 2'($urandom);
    e.sel = v.sel; e.q = v.q; e.r = v.r; e.dz = v.dz;
    sb.push_back(e);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("dz_on_accept", 32'(bus.div_by_zero), 32'(v.dz));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    if (lat == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within 40 edges for %0d/%0d", v.dvd, v.dvs);
    end else begin
      chk("done_latency", 32'(lat), 32'(lat_exp));
      shadow[e.sel] = e.q;
      shadow_rem    = e.r;
      chk("busy_at_done", 32'(bus.busy), 32'd0);
      chk("dz_at_done", 32'(bus.div_by_zero), 32'(e.dz));
      check_all($sformatf("op_%0d_%0d", v.dvd, v.dvs));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   dones;
    int   done_edge;

    for (int i = 0; i < 4; i++) shadow[i] = '0;
    shadow_rem   = '0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.sel      = '0;

    // Reset state.
    #12;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_dz", 32'(bus.div_by_zero), 32'd0);
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, then back-to-back sel 0..3, then random operands.
    vecs.push_back(mk(16'd1000,  8'd7,   2'd2, 16'd142,   8'd6,   1'b0));
    vecs.push_back(mk(16'd65535, 8'd1,   2'd0, 16'hFFFF,  8'd0,   1'b0));
    vecs.push_back(mk(16'd5,     8'd200, 2'd3, 16'd0,     8'd5,   1'b0));
    vecs.push_back(mk(16'h1234,  8'd0,   2'd1, 16'hFFFF,  8'h34,  1'b1));
    vecs.push_back(mk(16'd100,   8'd10,  2'd1, 16'd10,    8'd0,   1'b0));
    vecs.push_back(mk(16'd1000,  8'd7,   2'd0, 16'd142,   8'd6,   1'b0));
    vecs.push_back(mk(16'd255,   8'd255, 2'd1, 16'd1,     8'd0,   1'b0));
    vecs.push_back(mk(16'd4096,  8'd16,  2'd2, 16'd256,   8'd0,   1'b0));
    vecs.push_back(mk(16'd7,     8'd8,   2'd3, 16'd0,     8'd7,   1'b0));
    for (int i = 0; i < 6; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      vecs.push_back(mk(a, b, 2'($urandom), 16'(a / {8'd0, b}), 8'(a % {8'd0, b}), 1'b0));
    end
    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

    // Start while busy and during FIN must be ignored.
    bus.dividend = 16'd300;
    bus.divisor  = 8'd4;
    bus.sel      = 2'd0;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e.sel = 2'd0; e.q = 16'd75; e.r = 8'd0; e.dz = 1'b0;
    sb.push_back(e);
    dones     = 0;
    done_edge = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 5 || k == 17) begin
        bus.dividend = 16'd9;
        bus.divisor  = 8'd3;
        bus.sel      = 2'd1;
        bus.start    = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        done_edge = k;
      end
    end
    chk("busy_ignore_done_count", 32'(dones), 32'd1);
    chk("busy_ignore_done_edge", 32'(done_edge), 32'd17);
    chk("busy_ignore_idle", 32'(bus.busy), 32'd0);
    e = sb.pop_front();
    shadow[e.sel] = e.q;
    shadow_rem    = e.r;
    check_all("busy_ignore");

    // Reset in the middle of a division clears everything immediately.
    bus.dividend = 16'd500;
    bus.divisor  = 8'd3;
    bus.sel      = 2'd0;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    shadow_rem = '0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_dz", 32'(bus.div_by_zero), 32'd0);
    check_all("midrst");
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("post_rst_idle_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_idle_done", 32'(bus.done), 32'd0);
    end
    check_all("post_rst");

    // Normal operation resumes after reset.
    do_op(mk(16'd1000, 8'd7, 2'd2, 16'd142, 8'd6, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
